// File: rtl/sha_pkg.sv
// Shared constants for the SHA-2 message schedule: round counts, widths,
// sequencer state encoding and the 80-entry SHA-512 round-constant table.
package sha_pkg;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;
  localparam int WORD_W        = 64;
  localparam int WORD_W_256    = 32;
  localparam int BLK_W         = 1024;
  localparam int WIN_DEPTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // SHA-256 constants are the upper halves of entries 0..63.
  localparam logic [WORD_W-1:0] SHA_K [SHA512_ROUNDS] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/sha_sigma.sv
// Small-sigma functions of the SHA-2 message schedule; 32-bit variants
// (mode 0) return their result zero-extended in the low half.
module sha_sigma
  import sha_pkg::*;
(
  input  logic              mode,
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  logic [WORD_W_256-1:0] x_lo;

  always_comb begin
    s0   = '0;
    s1   = '0;
    x_lo = x[WORD_W_256-1:0];
    if (mode) begin
      s0 = {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
      s1 = {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    end else begin
      s0 = {32'h0, {x_lo[6:0], x_lo[31:7]} ^ {x_lo[17:0], x_lo[31:18]} ^ (x_lo >> 3)};
      s1 = {32'h0, {x_lo[16:0], x_lo[31:17]} ^ {x_lo[18:0], x_lo[31:19]} ^ (x_lo >> 10)};
    end
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256/512 message schedule and round sequencer: accepts one 16-word block,
// then streams W_t/K_t per round and pulses done after the last round.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | ready for a block; outputs zeroed
//   RUN     | one round per cycle, window shifts each cycle
//   DONE    | single done pulse, then back to IDLE
module sha_msg_schedule
  import sha_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  output logic              mode_q,
  output logic              round_valid,
  output logic [6:0]        round_idx,
  output logic              init,
  output logic [WORD_W-1:0] W,
  output logic [WORD_W-1:0] K,
  output logic              done
);

  sched_state_e      state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [6:0]        last_t;
  logic              mode_d;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];
  logic [WORD_W-1:0] win_d [WIN_DEPTH];

  logic [WORD_W-1:0] s0_w1, s1_w14, s1_unused, s0_unused;
  logic [WORD_W-1:0] sum_w, next_w, k_full;

  logic              blk_ready_d, round_valid_d, init_d, done_d;
  logic [6:0]        round_idx_d;
  logic [WORD_W-1:0] w_d, k_d;

  // Each instance contributes only one of its two sigma outputs.
  sha_sigma u_sigma_w1 (
    .mode (mode_q),
    .x    (win_q[1]),
    .s0   (s0_w1),
    .s1   (s1_unused)
  );

  sha_sigma u_sigma_w14 (
    .mode (mode_q),
    .x    (win_q[14]),
    .s0   (s0_unused),
    .s1   (s1_w14)
  );

  always_comb begin
    sum_w  = s1_w14 + win_q[9] + s0_w1 + win_q[0];
    next_w = mode_q ? sum_w : {32'h0, sum_w[WORD_W_256-1:0]};
    last_t = mode_q ? 7'(SHA512_ROUNDS - 1) : 7'(SHA256_ROUNDS - 1);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    mode_d  = mode_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          mode_d  = mode;
          t_d     = '0;
          state_d = ST_RUN;
          for (int i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = mode ? blk_data[BLK_W-1-WORD_W*i -: WORD_W]
                            : {32'h0, blk_data[BLK_W/2-1-WORD_W_256*i -: WORD_W_256]};
          end
        end
      end
      ST_RUN: begin
        for (int i = 0; i < WIN_DEPTH - 1; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[WIN_DEPTH-1] = next_w;
        if (t_q == last_t) begin
          state_d = ST_DONE;
        end else begin
          t_d = t_q + 7'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state will present.
  always_comb begin
    k_full        = SHA_K[t_d];
    blk_ready_d   = (state_d == ST_IDLE);
    round_valid_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_DONE);
    round_idx_d   = '0;
    init_d        = 1'b0;
    w_d           = '0;
    k_d           = '0;
    if (state_d == ST_RUN) begin
      round_idx_d = t_d;
      init_d      = (t_d == 7'd0);
      w_d         = win_d[0];
      k_d         = mode_d ? k_full : {32'h0, k_full[WORD_W-1:WORD_W_256]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      mode_q      <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
      blk_ready   <= 1'b1;
      round_valid <= 1'b0;
      round_idx   <= '0;
      init        <= 1'b0;
      W           <= '0;
      K           <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      mode_q      <= mode_d;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= win_d[i];
      end
      blk_ready   <= blk_ready_d;
      round_valid <= round_valid_d;
      round_idx   <= round_idx_d;
      init        <= init_d;
      W           <= w_d;
      K           <= k_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: a timeline model with the textbook W_t recurrence
// and K constants derived from cube roots of primes, checked every cycle.
module tb_sha_msg_schedule;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic          blk_valid = 1'b0;
  logic [1023:0] blk_data = '0;
  logic          blk_ready, mode_q, round_valid, init, done;
  logic [6:0]    round_idx;
  logic [63:0]   W, K;

  always #5 clk = ~clk;

  sha_msg_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .mode_q      (mode_q),
    .round_valid (round_valid),
    .round_idx   (round_idx),
    .init        (init),
    .W           (W),
    .K           (K),
    .done        (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference constants and schedule ----------------
  logic [63:0] kref [80];
  logic [63:0] mw [80];

  function automatic logic [63:0] cbrt_frac(input int p);
    logic [255:0] tgt, x, cand, cube;
    tgt = 256'(p) << 192;
    x = '0;
    for (int b = 67; b >= 0; b--) begin
      cand = x | (256'(1) << b);
      cube = cand * cand * cand;
      if (cube <= tgt) x = cand;
    end
    return x[63:0];
  endfunction

  task automatic build_k();
    int n = 0;
    for (int c = 2; n < 80; c++) begin
      bit isp = 1'b1;
      for (int d = 2; d * d <= c; d++) if (c % d == 0) isp = 1'b0;
      if (isp) begin
        kref[n] = cbrt_frac(c);
        n++;
      end
    end
  endtask

  function automatic logic [63:0] rotr(input logic m, input logic [63:0] v, input int n);
    logic [31:0] v32;
    if (m) return (v >> n) | (v << (64 - n));
    v32 = v[31:0];
    return {32'h0, (v32 >> n) | (v32 << (32 - n))};
  endfunction

  function automatic logic [63:0] sig0(input logic m, input logic [63:0] v);
    if (m) return rotr(1'b1, v, 1) ^ rotr(1'b1, v, 8) ^ (v >> 7);
    return rotr(1'b0, v, 7) ^ rotr(1'b0, v, 18) ^ {32'h0, v[31:0] >> 3};
  endfunction

  function automatic logic [63:0] sig1(input logic m, input logic [63:0] v);
    if (m) return rotr(1'b1, v, 19) ^ rotr(1'b1, v, 61) ^ (v >> 6);
    return rotr(1'b0, v, 17) ^ rotr(1'b0, v, 19) ^ {32'h0, v[31:0] >> 10};
  endfunction

  task automatic build_sched(input logic m, input logic [1023:0] d);
    logic [63:0] s;
    for (int t = 0; t < 16; t++)
      mw[t] = m ? d[1023 - 64*t -: 64] : {32'h0, d[511 - 32*t -: 32]};
    for (int t = 16; t < 80; t++) begin
      s = sig1(m, mw[t-2]) + mw[t-7] + sig0(m, mw[t-15]) + mw[t-16];
      mw[t] = m ? s : (s & 64'h0000_0000_FFFF_FFFF);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_ph: -1 idle, 0..m_n-1 round shown, m_n done pulse shown.
  int   m_ph = -1;
  int   m_n = 64;
  logic m_mode = 1'b0;
  int   acc_cnt = 0;
  int   acc_hist [512];
  bit   cmp_en = 1'b0;

  initial begin
    build_k();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_ph = -1;
        m_mode = 1'b0;
      end else if (m_ph < 0) begin
        if (blk_valid) begin
          m_mode = mode;
          m_n = mode ? 80 : 64;
          build_sched(mode, blk_data);
          m_ph = 0;
          acc_hist[acc_cnt] = cyc;
          acc_cnt++;
        end
      end else if (m_ph < m_n) begin
        m_ph++;
      end else begin
        m_ph = -1;
      end
      cyc++;
      cmp_en = 1'b1;
    end
  end

  // ---------------- compare + monitor ----------------
  logic [63:0] obs_w [128];
  logic [63:0] obs_k [128];
  int          init_cnt = 0, done_cnt = 0, done_cyc = 0, hi_cnt = 0;
  logic [63:0] ew, ek;
  logic [11:0] ectl;

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      ew = '0;
      ek = '0;
      if (m_ph < 0) begin
        ectl = {1'b1, 1'b0, 1'b0, 1'b0, m_mode, 7'd0};
      end else if (m_ph < m_n) begin
        ew = mw[m_ph];
        ek = m_mode ? kref[m_ph] : {32'h0, kref[m_ph][63:32]};
        ectl = {1'b0, 1'b1, (m_ph == 0), 1'b0, m_mode, 7'(m_ph)};
      end else begin
        ectl = {1'b0, 1'b0, 1'b0, 1'b1, m_mode, 7'd0};
      end
      chk("W", W, ew);
      chk("K", K, ek);
      chk("ctl{rdy,rv,init,done,mode_q,idx}",
          64'({blk_ready, round_valid, init, done, mode_q, round_idx}), 64'(ectl));
      if (round_valid) begin
        obs_w[round_idx] = W;
        obs_k[round_idx] = K;
        if (W[63:32] != 32'h0 || K[63:32] != 32'h0) hi_cnt++;
      end
      if (init) init_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_block(input logic m, input logic [1023:0] d);
    int a0 = acc_cnt;
    int n = 0;
    mode = m;
    blk_data = d;
    blk_valid = 1'b1;
    while (acc_cnt == a0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    blk_valid = 1'b0;
    chk("accept_seen", 64'(acc_cnt != a0), 64'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic wait_round(input int t);
    int n = 0;
    while (!(round_valid && round_idx == 7'(t)) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("round_reached", 64'(round_valid && round_idx == 7'(t)), 64'd1);
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [1023:0] d;
  int a0, i0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_ready", 64'(blk_ready), 64'd1);
    chk("reset_rv", 64'(round_valid), 64'd0);
    chk("reset_modeq", 64'(mode_q), 64'd0);
    chk("kref0", kref[0], 64'h428A2F98D728AE22);
    chk("kref63_hi", 64'(kref[63][63:32]), 64'hC67178F2);
    chk("kref79", kref[79], 64'h6C44198C4A475817);

    // SHA-256 "abc", junk in the ignored upper half
    d = rand_blk();
    d[511:0] = '0;
    d[511:480] = 32'h61626380;
    d[31:0] = 32'h00000018;
    @(posedge clk); #1;
    send_block(1'b0, d);
    wait_done();
    chk("abc256_w0", obs_w[0], 64'h61626380);
    chk("abc256_w15", obs_w[15], 64'h18);
    chk("abc256_w16", obs_w[16], 64'h61626380);
    chk("abc256_w17", obs_w[17], 64'h000F0000);
    chk("abc256_model_w17", mw[17], 64'h000F0000);
    chk("abc256_k0", obs_k[0], 64'h428A2F98);
    chk("abc256_k63", obs_k[63], 64'hC67178F2);
    chk("abc256_done_lat", 64'(done_cyc - acc_hist[acc_cnt-1]), 64'd65);

    // SHA-512 "abc"
    d = '0;
    d[1023:960] = 64'h6162638000000000;
    d[63:0] = 64'h18;
    send_block(1'b1, d);
    wait_done();
    chk("abc512_w0", obs_w[0], 64'h6162638000000000);
    chk("abc512_w15", obs_w[15], 64'h18);
    chk("abc512_w16", obs_w[16], 64'h6162638000000000);
    chk("abc512_k0", obs_k[0], 64'h428A2F98D728AE22);
    chk("abc512_k79", obs_k[79], 64'h6C44198C4A475817);
    chk("abc512_done_lat", 64'(done_cyc - acc_hist[acc_cnt-1]), 64'd81);

    // held valid: back-to-back blocks
    a0 = acc_cnt;
    i0 = init_cnt;
    mode = 1'b0;
    blk_data = rand_blk();
    blk_valid = 1'b1;
    for (int n = 0; n < 300 && acc_cnt < a0 + 2; n++) begin
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    chk("b2b_two_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("b2b_spacing", 64'(acc_hist[a0+1] - acc_hist[a0]), 64'd66);
    wait_done();
    chk("b2b_init_count", 64'(init_cnt - i0), 64'd2);

    // mode toggle mid-block
    hi_cnt = 0;
    send_block(1'b0, rand_blk());
    wait_round(10);
    mode = 1'b1;
    wait_done();
    chk("toggle_modeq", 64'(mode_q), 64'd0);
    chk("toggle_upper_zero", 64'(hi_cnt), 64'd0);
    chk("toggle_done_lat", 64'(done_cyc - acc_hist[acc_cnt-1]), 64'd65);
    mode = 1'b0;

    // reset mid-block
    send_block(1'b0, rand_blk());
    wait_round(30);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_rv", 64'(round_valid), 64'd0);
    chk("rst_w", W, 64'd0);
    chk("rst_k", K, 64'd0);
    chk("rst_ready", 64'(blk_ready), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

    // reset wins over a simultaneous accept
    a0 = acc_cnt;
    d = rand_blk();
    blk_data = d;
    blk_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_vs_accept_rv", 64'(round_valid), 64'd0);
    chk("rst_vs_accept_cnt", 64'(acc_cnt - a0), 64'd0);
    send_block(1'b0, d);
    wait_done();
    chk("post_rst_w0", obs_w[0], {32'h0, d[511:480]});

    // randomized blocks, both modes
    for (int b = 0; b < 200; b++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_block(b >= 100, rand_blk());
      mode = 1'($urandom());
      wait_done();
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
